// File: rtl/timer_apb_sequencer_pkg.sv
// timer_apb_sequencer_pkg
// Shared definitions for the timer APB sequencer:
//   - timer register addresses (PADDR[4:2])
//   - CTRL register bit positions and a helper that builds the CTRL word
//   - sequencer FSM state type and APB transfer-engine phase type
// Optional feature macro: TIMER_APB_SEQUENCER_VERIFY_EN (adds readback states).
package timer_apb_sequencer_pkg;

  localparam logic [2:0] ADDR_LOAD     = 3'b000;
  localparam logic [2:0] ADDR_VALUE    = 3'b001;
  localparam logic [2:0] ADDR_CTRL     = 3'b010;
  localparam logic [2:0] ADDR_PRESCALE = 3'b011;
  localparam logic [2:0] ADDR_CLEAR    = 3'b100;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_IE_BIT      = 1;
  localparam int unsigned CTRL_ONESHOT_BIT = 2;

  typedef enum logic [3:0] {
    sIdle,
    sWLoad,
    sWPre,
    sWCtrl,
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
    sRLoad,
    sRCtrl,
`endif
    sRun,
    sWClr,
    sHold,
    sRVal,
    sWStop
  } seqState_t;

  typedef enum logic [1:0] {
    xIdle,
    xSetup,
    xAccess
  } xferPhase_t;

  // CTRL word for a running timer: enabled, interrupt enabled, mode bit.
  function automatic logic [31:0] ctrlWord(input logic oneshot);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]      = 1'b1;
    w[CTRL_IE_BIT]      = 1'b1;
    w[CTRL_ONESHOT_BIT] = oneshot;
    return w;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// apb_master_xfer
// Single-transfer APB master engine. A request (held level) launches one
// SETUP cycle followed by ACCESS cycles until PREADY. Address, direction and
// data are registered at launch and stay stable for the whole transfer;
// between transfers PSEL/PENABLE/PWDATA are 0.
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   req                 request a transfer (sampled while idle)
//   addr, write, wdata  transfer attributes
//   done                combinational pulse on the completing ACCESS cycle
//   rdata               read data, valid while done is high
//   PSEL..PWDATA        APB master outputs
//   PRDATA, PREADY      APB slave responses
module apb_master_xfer
  import timer_apb_sequencer_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req,
  input  logic [2:0]  addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [2:0]  PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  xferPhase_t phase, phaseNext;
  logic       launch;

  always_comb begin
    phaseNext = phase;
    launch    = 1'b0;
    case (phase)
      xIdle: begin
        if (req) begin
          phaseNext = xSetup;
          launch    = 1'b1;
        end
      end
      xSetup:  phaseNext = xAccess;
      xAccess: if (PREADY) phaseNext = xIdle;
      default: phaseNext = xIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      phase  <= xIdle;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else begin
      phase <= phaseNext;
      if (launch) begin
        PADDR  <= addr;
        PWRITE <= write;
        PWDATA <= write ? wdata : '0;
      end else if (done) begin
        PADDR  <= '0;
        PWRITE <= 1'b0;
        PWDATA <= '0;
      end
    end
  end

  assign PSEL    = (phase != xIdle);
  assign PENABLE = (phase == xAccess);
  assign done    = (phase == xAccess) && PREADY;
  assign rdata   = PRDATA;

endmodule

// File: rtl/timer_apb_sequencer.sv
// timer_apb_sequencer
// APB master that configures a timer (LOAD, PRESCALE, CTRL), services each
// timer interrupt with a CLEAR write, counts serviced expiries, and performs
// on-demand VALUE snapshot reads.
// Ports:
//   PCLK, PRESET         clock, synchronous active-high reset
//   start, stop          control pulses
//   oneshot, load_value, prescale   configuration captured on start
//   snap_req             snapshot request pulse (RUN only)
//   PSEL..PWDATA, PRDATA, PREADY    APB master port to the timer
//   TIMINT               timer interrupt (polarity set by INTACTIVEH)
//   busy, tick, tick_count          status / expiry reporting
//   snap_valid, snap_data           snapshot result
//   cfg_err              sticky readback mismatch (feature builds only)
// Optional feature macro: TIMER_APB_SEQUENCER_VERIFY_EN reads LOAD and CTRL
// back after configuration and stops the timer on any mismatch.
module timer_apb_sequencer
  import timer_apb_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INTACTIVEH = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] load_value,
  input  logic [3:0]       prescale,
  input  logic             snap_req,
  output logic             PSEL,
  output logic             PENABLE,
  output logic [2:0]       PADDR,
  output logic             PWRITE,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY,
  input  logic             TIMINT,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             snap_valid,
  output logic [WIDTH-1:0] snap_data,
  output logic             cfg_err
);

  localparam int unsigned HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

  seqState_t         state, stateNext;
  logic              oneshotQ;
  logic [WIDTH-1:0]  loadQ;
  logic [3:0]        prescaleQ;
  logic              stopPending;
  logic [HOLD_W-1:0] holdCnt;
  logic [CNT_W-1:0]  tickCountQ;
  logic              tickQ;
  logic              snapValidQ;
  logic [WIDTH-1:0]  snapDataQ;

  logic              xReq;
  logic [2:0]        xAddr;
  logic              xWrite;
  logic [31:0]       xWdata;
  logic              xDone;
  logic [31:0]       xRdata;

  logic [31:0]       loadExt;
  logic              intActive;
  logic              stopNow;
  logic              holdLast;

`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
  logic              cfgErrQ;
  logic              loadMismatch;
  logic              ctrlMismatch;
  logic [31:0]       ctrlExp;
`endif

  apb_master_xfer uXfer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     (xReq),
    .addr    (xAddr),
    .write   (xWrite),
    .wdata   (xWdata),
    .done    (xDone),
    .rdata   (xRdata),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  always_comb begin
    stateNext = state;
    xReq      = 1'b0;
    xAddr     = ADDR_LOAD;
    xWrite    = 1'b0;
    xWdata    = '0;
    loadExt   = '0;
    loadExt[WIDTH-1:0] = loadQ;
    intActive = (INTACTIVEH != 0) ? TIMINT : ~TIMINT;
    // A stop seen outside RUN is remembered; the live pulse counts too.
    stopNow   = stop || stopPending;
    holdLast  = (holdCnt == HOLD_W'(HOLDOFF - 1));
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
    ctrlExp      = ctrlWord(oneshotQ);
    loadMismatch = (xRdata[WIDTH-1:0] != loadQ);
    ctrlMismatch = (xRdata[2:0] != ctrlExp[2:0]);
`endif
    case (state)
      sIdle: if (start) stateNext = sWLoad;
      sWLoad: begin
        xReq = 1'b1; xAddr = ADDR_LOAD; xWrite = 1'b1; xWdata = loadExt;
        if (xDone) stateNext = sWPre;
      end
      sWPre: begin
        xReq = 1'b1; xAddr = ADDR_PRESCALE; xWrite = 1'b1; xWdata = 32'(prescaleQ);
        if (xDone) stateNext = sWCtrl;
      end
      sWCtrl: begin
        xReq = 1'b1; xAddr = ADDR_CTRL; xWrite = 1'b1; xWdata = ctrlWord(oneshotQ);
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
        if (xDone) stateNext = sRLoad;
`else
        if (xDone) stateNext = sRun;
`endif
      end
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
      sRLoad: begin
        xReq = 1'b1; xAddr = ADDR_LOAD;
        if (xDone) stateNext = sRCtrl;
      end
      sRCtrl: begin
        xReq = 1'b1; xAddr = ADDR_CTRL;
        if (xDone) stateNext = (cfgErrQ || ctrlMismatch) ? sWStop : sRun;
      end
`endif
      sRun: begin
        if (intActive)     stateNext = sWClr;
        else if (stopNow)  stateNext = sWStop;
        else if (snap_req) stateNext = sRVal;
      end
      sWClr: begin
        xReq = 1'b1; xAddr = ADDR_CLEAR; xWrite = 1'b1;
        if (xDone) stateNext = sHold;
      end
      sHold: if (holdLast) stateNext = (oneshotQ || stopNow) ? sWStop : sRun;
      sRVal: begin
        xReq = 1'b1; xAddr = ADDR_VALUE;
        if (xDone) stateNext = sRun;
      end
      sWStop: begin
        xReq = 1'b1; xAddr = ADDR_CTRL; xWrite = 1'b1;
        if (xDone) stateNext = sIdle;
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= sIdle;
      oneshotQ    <= 1'b0;
      loadQ       <= '0;
      prescaleQ   <= '0;
      stopPending <= 1'b0;
      holdCnt     <= '0;
      tickCountQ  <= '0;
      tickQ       <= 1'b0;
      snapValidQ  <= 1'b0;
      snapDataQ   <= '0;
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
      cfgErrQ     <= 1'b0;
`endif
    end else begin
      state      <= stateNext;
      tickQ      <= 1'b0;
      snapValidQ <= 1'b0;
      holdCnt    <= (state == sHold) ? holdCnt + 1'b1 : '0;

      if (state == sIdle && start) begin
        oneshotQ   <= oneshot;
        loadQ      <= load_value;
        prescaleQ  <= prescale;
        tickCountQ <= '0;
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
        cfgErrQ    <= 1'b0;
`endif
      end

      if (state == sIdle || state == sWStop) stopPending <= 1'b0;
      else if (stop)                         stopPending <= 1'b1;

      if (state == sWClr && xDone) begin
        tickQ      <= 1'b1;
        tickCountQ <= tickCountQ + 1'b1;
      end

      if (state == sRVal && xDone) begin
        snapValidQ <= 1'b1;
        snapDataQ  <= xRdata[WIDTH-1:0];
      end

`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
      if (state == sRLoad && xDone && loadMismatch) cfgErrQ <= 1'b1;
      if (state == sRCtrl && xDone && ctrlMismatch) cfgErrQ <= 1'b1;
`endif
    end
  end

  assign busy       = (state != sIdle);
  assign tick       = tickQ;
  assign tick_count = tickCountQ;
  assign snap_valid = snapValidQ;
  assign snap_data  = snapDataQ;
`ifdef TIMER_APB_SEQUENCER_VERIFY_EN
  assign cfg_err    = cfgErrQ;
`else
  assign cfg_err    = 1'b0;
`endif

endmodule
